// File: rtl/mult_hilo_unit.sv
// MULT/MULTU unit with architectural HI/LO registers and a fixed-latency multicycle product path.
// Define MULT_HILO_SIGNED_EN to honour signed_op (MULT); without it every multiply is unsigned.
module mult_hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             state_dbg
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Handshake: start is taken only in IDLE; while busy=1 the upstream stalls and any
  // start/mthi/mtlo presented is dropped. done pulses once, when HI/LO first show the product.

  state_t             state, state_nx;
  logic [3:0]         count;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mag_a_nx, mag_b_nx;
  logic [2*WIDTH-1:0] product, result;
  logic               accept, finish;

  assign accept = (state == IDLE) && start;
  assign finish = (state == BUSY) && (count == 4'd0);

`ifdef MULT_HILO_SIGNED_EN
  logic res_sign;

  // Negating the most-negative value wraps back to itself, which read as unsigned is 2^(WIDTH-1).
  assign mag_a_nx = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b_nx = (signed_op && b[WIDTH-1]) ? -b : b;
  assign result   = res_sign ? -product : product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sign <= 1'b0;
    end else if (accept) begin
      res_sign <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_op;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign mag_a_nx         = a;
  assign mag_b_nx         = b;
  assign result           = product;
`endif

  // Fed only from registers that are stable for the whole BUSY window.
  M_ARRAY_MULT #(.N(WIDTH)) u_array_mult (
    .a (mag_a),
    .b (mag_b),
    .p (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (count == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == BUSY);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
      mag_a <= '0;
      mag_b <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        mag_a <= mag_a_nx;
        mag_b <= mag_b_nx;
        count <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      // A move sharing a cycle with an accepted start loses to the multiply.
      if (finish) begin
        {hi, lo} <= result;
      end else if ((state == IDLE) && !start) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// Unsigned N x N array multiplier: one shifted partial product per multiplier bit.
module M_ARRAY_MULT #(
  parameter int N = 32
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] acc [N+1];

  assign acc[0] = '0;

  for (genvar i = 0; i < N; i++) begin : g_row
    assign acc[i+1] = acc[i] + (b[i] ? ({{N{1'b0}}, a} << i) : {(2*N){1'b0}});
  end

  assign p = acc[N];

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: directed corner cases then random traffic, scored against a plain-arithmetic model.
module tb_mult_hilo_unit;
  localparam int W = 32;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, state_dbg;
  logic [W-1:0] hi, lo;

  mult_hilo_unit #(.WIDTH(W), .LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  int             busy_from = 1;
  int             busy_to   = 0;
  logic [W-1:0]   model_hi  = '0;
  logic [W-1:0]   model_lo  = '0;
  int             checks = 0;
  int             errors = 0;

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] x, logic [W-1:0] y, logic s);
    logic [2*W-1:0] u;
    u = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`ifdef MULT_HILO_SIGNED_EN
    if (s) return 64'(longint'($signed(x)) * longint'($signed(y)));
`endif
    return s ? u : u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [2*W-1:0] e;
    int             ec;
    check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
    if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0]) begin
      checks++;
      errors++;
      $display("FAIL missed_done: no done by cycle %0d, expected at %0d", cyc, exp_cyc_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done at cycle %0d: done=1 expected 0", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("product", {hi, lo}, e);
        check("done_cycle", 64'(cyc), 64'(ec));
        model_hi = e[2*W-1:W];
        model_lo = e[W-1:0];
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic mult_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit mv);
    int c;
    #1;
    c = cyc;
    a = x; b = y; signed_op = s; start = 1'b1;
    if (mv) begin
      mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
    end
    if (!(c >= busy_from && c <= busy_to)) begin
      exp_q.push_back(ref_mul(x, y, s));
      exp_cyc_q.push_back(c + L + 1);
      busy_from = c + 1;
      busy_to   = c + L;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic move_op(input bit h, input bit l, input logic [W-1:0] d);
    int c;
    #1;
    c = cyc;
    mthi = h; mtlo = l; wdata = d;
    if (!(c >= busy_from && c <= busy_to)) begin
      if (h) model_hi = d;
      if (l) model_lo = d;
    end
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    #1;
    check("move_hi", 64'(hi), 64'(model_hi));
    check("move_lo", 64'(lo), 64'(model_lo));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || cyc <= busy_to) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL idle_timeout: %0d results still pending after %0d cycles, expected 0", exp_q.size(), n);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);

    // First start right on the first edge after release.
    rst = 1'b0;
    mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle();
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);

    mult_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0);
    wait_idle();
    mult_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    wait_idle();

    move_op(1'b1, 1'b0, 32'h1234_5678);
    move_op(1'b0, 1'b1, 32'hDEAD_BEEF);
    move_op(1'b1, 1'b1, 32'hCAFE_F00D);

    // Move while busy is dropped; the product lands on both halves.
    mult_op(32'h0001_0003, 32'h0000_0101, 1'b0, 1'b0);
    move_op(1'b0, 1'b1, 32'h5555_AAAA);
    wait_idle();

    // Second start while busy is ignored.
    mult_op(32'd5, 32'd6, 1'b0, 1'b0);
    mult_op(32'd2, 32'd2, 1'b0, 1'b0);
    wait_idle();
    check("ignored_start_lo", 64'(lo), 64'h1E);
    check("ignored_start_hi", 64'(hi), 64'h0);

    // Start together with a move: start wins.
    mult_op(32'd3, 32'd4, 1'b0, 1'b1);
    wait_idle();

    // Reset in the second busy cycle aborts the multiply.
    mult_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    busy_from = 1;
    busy_to   = 0;
    model_hi  = '0;
    model_lo  = '0;
    @(negedge clk);
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7)
        mult_op(pick(), pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      else
        move_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
